fir_out_decimator: RTL and testbench

FIR_OUT_DECIMATOR -- requirements
Module: fir_out_decimator

---
 rtl/fir_out_decimator.sv | 102 ++++++++++
 tb/tb_fir_out_decimator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_decimator.sv
// FIR output decimator: offset-binary to signed, OSR-sample rounded average,
// result queued in a small FIFO with sticky overflow accounting.
module fir_out_decimator #(
    parameter int OSR        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] in,
    input  logic        in_valid,
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovf,
    output logic [7:0]  drop_cnt
);

    localparam int SH = $clog2(OSR);
    localparam int AW = 14 + SH;
    localparam int PW = (SH > 0) ? SH : 1;
    localparam int QW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [PW-1:0]        phase;
    logic signed [AW-1:0] acc;
    logic signed [13:0]   s;
    logic signed [AW-1:0] s_ext;
    logic signed [AW-1:0] sum;
    logic signed [AW:0]   rnd;
    logic signed [13:0]   avg;
    logic [15:0]          result;
    logic                 last;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [QW-1:0] rd_ptr;
    logic [QW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;

    assign s = {~in[13], in[12:0]};

    always_comb begin
        s_ext  = AW'(s);
        sum    = (phase == '0) ? s_ext : acc + s_ext;
        // OSR/2 is zero when OSR=1, so samples pass through unrounded
        rnd    = (AW+1)'(sum) + (AW+1)'(OSR / 2);
        avg    = 14'(rnd >>> SH);
        result = {avg, 2'b00};
        last   = (phase == PW'(OSR - 1));
    end

    assign out_valid = (count != '0);
    assign out       = out_valid ? mem[rd_ptr] : '0;
    assign full      = (count == CW'(FIFO_DEPTH));
    assign push      = in_valid && last;
    assign pop       = out_valid && out_ready;
    // A pop frees the slot the simultaneous push needs
    assign wr_en     = push && (!full || pop);

    function automatic logic [QW-1:0] nxt(input logic [QW-1:0] p);
        return (p == QW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            acc      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (in_valid) begin
                acc   <= sum;
                phase <= last ? '0 : phase + 1'b1;
            end
            if (wr_en)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            if (wr_en && !pop)
                count <= count + 1'b1;
            else if (!wr_en && pop)
                count <= count - 1'b1;
            if (push && !wr_en) begin
                ovf <= 1'b1;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            mem[wr_ptr] <= result;
    end

endmodule

// File: tb/tb_fir_out_decimator.sv
// Bench for fir_out_decimator: directed vectors plus randomized streams
// scored against an arithmetic model of averaging and a bounded queue.
module tb_fir_out_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] din;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] out4, out1;
    logic        ov4, ov1;
    logic        ovf4, ovf1;
    logic [7:0]  dc4, dc1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fir_out_decimator #(.OSR(4), .FIFO_DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
        .out(out4), .out_valid(ov4), .out_ready(out_ready),
        .ovf(ovf4), .drop_cnt(dc4)
    );

    fir_out_decimator #(.OSR(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
        .out(out1), .out_valid(ov1), .out_ready(out_ready),
        .ovf(ovf1), .drop_cnt(dc1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sval(input logic [13:0] r);
        return int'(r) - 8192;
    endfunction

    function automatic logic [15:0] ref_out(input int total, input int osr);
        int t, a;
        t = total + osr / 2;
        if (t >= 0) a = t / osr;
        else        a = -((-t + osr - 1) / osr);
        return 16'(a * 4);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        din = 14'h3FFF;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ov4 !== 1'b0 || out4 !== 16'h0)
            $display("FAIL reset_out4 valid=%b out=%h want 0/0000", ov4, out4);
        else passed++;
        checks++;
        if (ovf4 !== 1'b0 || dc4 !== 8'h0)
            $display("FAIL reset_flags4 ovf=%b drop=%0d want 0/0", ovf4, dc4);
        else passed++;
        checks++;
        if (ov1 !== 1'b0 || out1 !== 16'h0 || ovf1 !== 1'b0 || dc1 !== 8'h0)
            $display("FAIL reset_u1 valid=%b out=%h ovf=%b drop=%0d want 0",
                     ov1, out1, ovf1, dc1);
        else passed++;
    endtask

    task automatic send_group(input logic [13:0] a, input logic [13:0] b,
                              input logic [13:0] c, input logic [13:0] d,
                              input logic [15:0] exp, input string name);
        logic [13:0] v [4];
        logic early;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        early = 1'b0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = v[i];
            in_valid = 1'b1;
            step();
            if (i < 3 && ov4) early = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (early || ov4 !== 1'b1 || out4 !== exp)
            $display("FAIL %s early=%b valid=%b out=%h want 1/%h",
                     name, early, ov4, out4, exp);
        else passed++;
        step();
        checks++;
        if (ov4 !== 1'b0)
            $display("FAIL %s_onecycle valid=%b want 0", name, ov4);
        else passed++;
    endtask

    task automatic test_directed();
        send_group(14'h2000, 14'h2000, 14'h2000, 14'h2000, 16'h0000, "mid");
        send_group(14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF, 16'h7FFC, "posfs");
        send_group(14'h0000, 14'h0000, 14'h0000, 14'h0000, 16'h8000, "negfs");
        send_group(14'h2000, 14'h2000, 14'h2000, 14'h2002, 16'h0004, "rnd_up");
        send_group(14'h1FFF, 14'h1FFF, 14'h1FFF, 14'h1FFF, 16'hFFFC, "rnd_neg");
        send_group(14'h1FFF, 14'h2000, 14'h2000, 14'h2000, 16'h0000, "rnd_zero");
    endtask

    task automatic test_backpressure();
        logic [15:0] exp [5];
        for (int g = 1; g <= 5; g++)
            exp[g-1] = ref_out(4 * sval(14'(g)), 4);
        do_reset();
        out_ready = 1'b0;
        for (int g = 1; g <= 5; g++)
            for (int k = 0; k < 4; k++) begin
                din = 14'(g);
                in_valid = 1'b1;
                step();
            end
        in_valid = 1'b0;
        checks++;
        if (ov4 !== 1'b1 || out4 !== exp[0])
            $display("FAIL bp_head valid=%b out=%h want 1/%h", ov4, out4, exp[0]);
        else passed++;
        checks++;
        if (ovf4 !== 1'b1 || dc4 !== 8'd1)
            $display("FAIL bp_ovf ovf=%b drop=%0d want 1/1", ovf4, dc4);
        else passed++;
        step();
        checks++;
        if (out4 !== exp[0])
            $display("FAIL bp_stable out=%h want %h", out4, exp[0]);
        else passed++;
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            checks++;
            if (ov4 !== 1'b1 || out4 !== exp[i])
                $display("FAIL bp_drain%0d valid=%b out=%h want 1/%h",
                         i, ov4, out4, exp[i]);
            else passed++;
        end
        step();
        checks++;
        if (ov4 !== 1'b0 || ovf4 !== 1'b1 || dc4 !== 8'd1)
            $display("FAIL bp_empty valid=%b ovf=%b drop=%0d want 0/1/1",
                     ov4, ovf4, dc4);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [15:0] got;
        n = 0;
        got = 16'hDEAD;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din = 14'h3FFF;
            in_valid = 1'b1;
            step();
            if (ov4) n++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            din = 14'h2000;
            in_valid = (i < 4);
            step();
            if (ov4) begin
                n++;
                got = out4;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n !== 1 || got !== 16'h0000)
            $display("FAIL reset_mid results=%0d out=%h want 1/0000", n, got);
        else passed++;
    endtask

    task automatic test_osr1();
        logic [13:0] vals [$];
        logic [15:0] exp;
        vals = '{14'h2001, 14'h1FFE};
        for (int i = 0; i < 10; i++) vals.push_back(14'($urandom));
        do_reset();
        out_ready = 1'b1;
        foreach (vals[i]) begin
            din = vals[i];
            in_valid = 1'b1;
            exp = ref_out(sval(vals[i]), 1);
            if (i == 0) exp = 16'h0004;
            if (i == 1) exp = 16'hFFF8;
            step();
            checks++;
            if (ov1 !== 1'b1 || out1 !== exp)
                $display("FAIL osr1_%0d in=%h valid=%b out=%h want 1/%h",
                         i, vals[i], ov1, out1, exp);
            else passed++;
            in_valid = 1'b0;
            din = 14'($urandom);
            step();
            checks++;
            if (ov1 !== 1'b0)
                $display("FAIL osr1_gap%0d valid=%b want 0", i, ov1);
            else passed++;
        end
    endtask

    task automatic test_random_stream();
        logic [15:0] q [$];
        int gsum, gn, mdrop;
        logic movf, pop, push;
        logic [15:0] res;
        gsum = 0; gn = 0; mdrop = 0; movf = 1'b0;
        res = '0;
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            din = 14'($urandom);
            if (cyc < 1000) out_ready = ($urandom_range(0, 2) == 0);
            else            out_ready = ($urandom_range(0, 3) != 0);
            pop = (q.size() != 0) && out_ready;
            push = 1'b0;
            if (in_valid) begin
                gsum += sval(din);
                gn++;
                if (gn == 4) begin
                    push = 1'b1;
                    res = ref_out(gsum, 4);
                    gsum = 0;
                    gn = 0;
                end
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < 4) q.push_back(res);
                else begin
                    movf = 1'b1;
                    if (mdrop < 255) mdrop++;
                end
            end
            step();
            checks++;
            if (ov4 !== (q.size() != 0) ||
                (q.size() != 0 && out4 !== q[0]))
                $display("FAIL rand_out cyc=%0d valid=%b out=%h want %b/%h",
                         cyc, ov4, out4, q.size() != 0,
                         (q.size() != 0) ? q[0] : 16'h0);
            else passed++;
            checks++;
            if (ovf4 !== movf || dc4 !== 8'(mdrop))
                $display("FAIL rand_flags cyc=%0d ovf=%b drop=%0d want %b/%0d",
                         cyc, ovf4, dc4, movf, mdrop);
            else passed++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        din = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_osr1();
        test_random_stream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
